// File: rtl/sdram_access_arbiter_if.sv
// rtl/sdram_access_arbiter_if.sv - client grant handshake and SDRAM glue bundle for the access arbiter
interface sdram_access_arbiter_if;
   logic        iC0_Rd_Req, iC0_Wr_Req, oC0_Rd_Ack, oC0_Wr_Ack, iC0_Rd_Done, iC0_Wr_Done;
   logic        iC1_Rd_Req, iC1_Wr_Req, oC1_Rd_Ack, oC1_Wr_Ack, iC1_Rd_Done, iC1_Wr_Done;
   logic [23:0] iC0_Rd_Addr, iC0_Wr_Addr, iC1_Rd_Addr, iC1_Wr_Addr;
   logic [15:0] iC0_Wr_Data, iC1_Wr_Data, oC0_SDRAM_Data, oC1_SDRAM_Data;
   logic        iC0_SDRAM_Rd_Req, iC0_SDRAM_Wr_Req, oC0_SDRAM_Rd_Done, oC0_SDRAM_Wr_Done;
   logic        iC1_SDRAM_Rd_Req, iC1_SDRAM_Wr_Req, oC1_SDRAM_Rd_Done, oC1_SDRAM_Wr_Done;
   logic [23:0] oSDRAM_Rd_Addr, oSDRAM_Wr_Addr;
   logic [15:0] iSDRAM_Data, oSDRAM_Wr_Data;
   logic        oSDRAM_Rd_Req, oSDRAM_Wr_Req, iSDRAM_Rd_Done, iSDRAM_Wr_Done;
   logic [2:0]  oGrant;
   logic [1:0]  oErr;

   modport slave (
      input  iC0_Rd_Req, iC0_Wr_Req, iC0_Rd_Done, iC0_Wr_Done,
      input  iC1_Rd_Req, iC1_Wr_Req, iC1_Rd_Done, iC1_Wr_Done,
      input  iC0_Rd_Addr, iC0_Wr_Addr, iC0_Wr_Data, iC0_SDRAM_Rd_Req, iC0_SDRAM_Wr_Req,
      input  iC1_Rd_Addr, iC1_Wr_Addr, iC1_Wr_Data, iC1_SDRAM_Rd_Req, iC1_SDRAM_Wr_Req,
      input  iSDRAM_Data, iSDRAM_Rd_Done, iSDRAM_Wr_Done,
      output oC0_Rd_Ack, oC0_Wr_Ack, oC1_Rd_Ack, oC1_Wr_Ack,
      output oC0_SDRAM_Data, oC1_SDRAM_Data,
      output oC0_SDRAM_Rd_Done, oC0_SDRAM_Wr_Done, oC1_SDRAM_Rd_Done, oC1_SDRAM_Wr_Done,
      output oSDRAM_Rd_Addr, oSDRAM_Wr_Addr, oSDRAM_Wr_Data, oSDRAM_Rd_Req, oSDRAM_Wr_Req,
      output oGrant, oErr
   );

   modport master (
      output iC0_Rd_Req, iC0_Wr_Req, iC0_Rd_Done, iC0_Wr_Done,
      output iC1_Rd_Req, iC1_Wr_Req, iC1_Rd_Done, iC1_Wr_Done,
      output iC0_Rd_Addr, iC0_Wr_Addr, iC0_Wr_Data, iC0_SDRAM_Rd_Req, iC0_SDRAM_Wr_Req,
      output iC1_Rd_Addr, iC1_Wr_Addr, iC1_Wr_Data, iC1_SDRAM_Rd_Req, iC1_SDRAM_Wr_Req,
      output iSDRAM_Data, iSDRAM_Rd_Done, iSDRAM_Wr_Done,
      input  oC0_Rd_Ack, oC0_Wr_Ack, oC1_Rd_Ack, oC1_Wr_Ack,
      input  oC0_SDRAM_Data, oC1_SDRAM_Data,
      input  oC0_SDRAM_Rd_Done, oC0_SDRAM_Wr_Done, oC1_SDRAM_Rd_Done, oC1_SDRAM_Wr_Done,
      input  oSDRAM_Rd_Addr, oSDRAM_Wr_Addr, oSDRAM_Wr_Data, oSDRAM_Rd_Req, oSDRAM_Wr_Req,
      input  oGrant, oErr
   );
endinterface

// File: rtl/sdram_access_arbiter.sv
// rtl/sdram_access_arbiter.sv - round-robin SDRAM access grant arbiter for two read/write clients
module sdram_access_arbiter #(
   parameter logic [23:0] TIMEOUT = 24'd0
) (
   input  logic                  clk,
   input  logic                  rst,
   sdram_access_arbiter_if.slave bus
);
   typedef enum logic [1:0] {IDLE, ACK, GRANT} state_t;

   // Source index ring: 0 C0_WR, 1 C0_RD, 2 C1_WR, 3 C1_RD; bit1 = client, bit0 = read
   state_t      state_q, state_d;
   logic [1:0]  src_q, src_d, ptr_q, ptr_d;
   logic [23:0] wd_cnt_q, wd_cnt_d;
   logic [1:0]  err_q, err_d;
   logic [23:0] rd_addr_q, rd_addr_d, wr_addr_q, wr_addr_d;
   logic [15:0] wr_data_q, wr_data_d;

   logic [3:0]  req;
   logic        in_grant, g_client, g_wr;
   logic        sel_rd_req, sel_wr_req, sel_rd_rel, sel_wr_rel;
   logic [23:0] sel_rd_addr, sel_wr_addr;
   logic [15:0] sel_wr_data;
   logic        release_hit, mismatch, expire;

   assign req         = {bus.iC1_Rd_Req, bus.iC1_Wr_Req, bus.iC0_Rd_Req, bus.iC0_Wr_Req};
   assign in_grant    = (state_q == GRANT);
   assign g_client    = src_q[1];
   assign g_wr        = ~src_q[0];

   assign sel_rd_req  = g_client ? bus.iC1_SDRAM_Rd_Req : bus.iC0_SDRAM_Rd_Req;
   assign sel_wr_req  = g_client ? bus.iC1_SDRAM_Wr_Req : bus.iC0_SDRAM_Wr_Req;
   assign sel_rd_addr = g_client ? bus.iC1_Rd_Addr      : bus.iC0_Rd_Addr;
   assign sel_wr_addr = g_client ? bus.iC1_Wr_Addr      : bus.iC0_Wr_Addr;
   assign sel_wr_data = g_client ? bus.iC1_Wr_Data      : bus.iC0_Wr_Data;
   assign sel_rd_rel  = g_client ? bus.iC1_Rd_Done      : bus.iC0_Rd_Done;
   assign sel_wr_rel  = g_client ? bus.iC1_Wr_Done      : bus.iC0_Wr_Done;

   assign release_hit = in_grant && (g_wr ? sel_wr_rel : sel_rd_rel);
   assign mismatch    = in_grant && (g_wr ? sel_rd_req : sel_wr_req);
   // Expiry lands on the TIMEOUT-th GRANT cycle so the requests drop within it
   assign expire      = in_grant && (TIMEOUT != 24'd0) && (wd_cnt_q == TIMEOUT - 24'd1);

   always_ff @(posedge clk) begin
      if (rst) begin
         state_q   <= IDLE;
         src_q     <= 2'd0;
         ptr_q     <= 2'd0;
         wd_cnt_q  <= 24'd0;
         err_q     <= 2'b00;
         rd_addr_q <= 24'd0;
         wr_addr_q <= 24'd0;
         wr_data_q <= 16'd0;
      end else begin
         state_q   <= state_d;
         src_q     <= src_d;
         ptr_q     <= ptr_d;
         wd_cnt_q  <= wd_cnt_d;
         err_q     <= err_d;
         rd_addr_q <= rd_addr_d;
         wr_addr_q <= wr_addr_d;
         wr_data_q <= wr_data_d;
      end
   end

   always_comb begin
      logic       found;
      logic [1:0] idx;
      state_d  = state_q;
      src_d    = src_q;
      ptr_d    = ptr_q;
      wd_cnt_d = wd_cnt_q;
      err_d    = err_q | {mismatch, expire};
      found    = 1'b0;
      idx      = 2'd0;
      case (state_q)
         IDLE: begin
            for (int i = 0; i < 4; i++) begin
               idx = ptr_q + 2'(i);
               if (!found && req[idx]) begin
                  found = 1'b1;
                  src_d = idx;
               end
            end
            if (found) state_d = ACK;
         end
         ACK: begin
            state_d  = GRANT;
            wd_cnt_d = 24'd0;
         end
         GRANT: begin
            wd_cnt_d = wd_cnt_q + 24'd1;
            if (release_hit || expire) begin
               state_d = IDLE;
               ptr_d   = src_q + 2'd1;
            end
         end
         default: state_d = IDLE;
      endcase
   end

   always_comb begin
      rd_addr_d = rd_addr_q;
      wr_addr_d = wr_addr_q;
      wr_data_d = wr_data_q;
      if (in_grant && !g_wr) rd_addr_d = sel_rd_addr;
      if (in_grant && g_wr) begin
         wr_addr_d = sel_wr_addr;
         wr_data_d = sel_wr_data;
      end
   end

   assign bus.oSDRAM_Rd_Addr    = rd_addr_d;
   assign bus.oSDRAM_Wr_Addr    = wr_addr_d;
   assign bus.oSDRAM_Wr_Data    = wr_data_d;
   assign bus.oSDRAM_Rd_Req     = in_grant && !g_wr && !expire && sel_rd_req;
   assign bus.oSDRAM_Wr_Req     = in_grant &&  g_wr && !expire && sel_wr_req;

   assign bus.oC0_Wr_Ack        = (state_q == ACK) && (src_q == 2'd0);
   assign bus.oC0_Rd_Ack        = (state_q == ACK) && (src_q == 2'd1);
   assign bus.oC1_Wr_Ack        = (state_q == ACK) && (src_q == 2'd2);
   assign bus.oC1_Rd_Ack        = (state_q == ACK) && (src_q == 2'd3);

   assign bus.oC0_SDRAM_Rd_Done = in_grant && !g_wr && !g_client && bus.iSDRAM_Rd_Done;
   assign bus.oC1_SDRAM_Rd_Done = in_grant && !g_wr &&  g_client && bus.iSDRAM_Rd_Done;
   assign bus.oC0_SDRAM_Wr_Done = in_grant &&  g_wr && !g_client && bus.iSDRAM_Wr_Done;
   assign bus.oC1_SDRAM_Wr_Done = in_grant &&  g_wr &&  g_client && bus.iSDRAM_Wr_Done;

   assign bus.oC0_SDRAM_Data    = bus.iSDRAM_Data;
   assign bus.oC1_SDRAM_Data    = bus.iSDRAM_Data;

   assign bus.oGrant            = in_grant ? {1'b1, g_client, g_wr} : 3'b000;
   assign bus.oErr              = err_d;
endmodule

// File: doc/sdram_access_arbiter.md
# sdram_access_arbiter

Responder side of the SDRAM access-grant handshake used by the draw engines. Accepts read and write grant requests from two clients (client 0: shift/draw engine, client 1: LCD refresh reader), grants exactly one client/type at a time with a single-cycle acknowledge, and routes that client's SDRAM glue signals to the single SDRAM controller port. The grant is held until the client pulses its done line. Sits between the drawing/refresh blocks and the SDRAM controller.

## Interface
- TIMEOUT, 0, grant watchdog length in cycles (24-bit). 0 disables the watchdog.
- clk  in  1  system clock; all logic on rising edge
- rst  in  1  synchronous, active-high reset
- For k in {0,1}, grant handshake:
  - iC<k>_Rd_Req / iC<k>_Wr_Req  in  1  client requests read / write grant; held until ack seen
  - oC<k>_Rd_Ack / oC<k>_Wr_Ack  out  1  single-cycle grant pulse
  - iC<k>_Rd_Done / iC<k>_Wr_Done  in  1  single-cycle release pulse
- For k in {0,1}, SDRAM glue from client:
  - iC<k>_Rd_Addr  in  24  read address, Bank(2)+Row(13)+Column(9)
  - iC<k>_SDRAM_Rd_Req  in  1  read strobe, level until done
  - oC<k>_SDRAM_Rd_Done  out  1  routed read-done
  - oC<k>_SDRAM_Data  out  16  read data, iSDRAM_Data broadcast
  - iC<k>_Wr_Addr  in  24, iC<k>_Wr_Data  in  16, iC<k>_SDRAM_Wr_Req  in  1  write glue
  - oC<k>_SDRAM_Wr_Done  out  1  routed write-done
- Controller side: oSDRAM_Rd_Addr out 24, oSDRAM_Rd_Req out 1, iSDRAM_Data in 16, iSDRAM_Rd_Done in 1, oSDRAM_Wr_Addr out 24, oSDRAM_Wr_Data out 16, oSDRAM_Wr_Req out 1, iSDRAM_Wr_Done in 1.
- oGrant  out  3  {valid, client, type(1=write)} of the current grant
- oErr  out  2  sticky: [0] watchdog expiry, [1] type mismatch

## Operation
- Four sources in fixed ring order: C0_WR, C0_RD, C1_WR, C1_RD. Round-robin pointer starts at the source after the last one granted. After reset it starts at C0_WR.
- States are IDLE, ACK, and GRANT.
  - IDLE: if any request is high, select the first source from the pointer, register the grant (client, type), and go to ACK.
  - ACK: assert that source's Ack for exactly one cycle, then go to GRANT. Other Acks stay 0.
  - GRANT: route glue for the granted client and type only. Leave on the granted Done pulse (matching client and type), or on watchdog expiry. Either way return to IDLE and set pointer = granted source + 1 (mod 4).
- Routing in GRANT, combinational from the registered grant:
  - Read grant: oSDRAM_Rd_Addr/Req come from the granted client. oSDRAM_Wr_Req=0.
  - Write grant: oSDRAM_Wr_Addr/Data/Req come from the granted client. oSDRAM_Rd_Req=0.
  - iSDRAM_Rd_Done / iSDRAM_Wr_Done go only to the granted client's matching done output. All other done outputs are 0.
- Outside GRANT, oSDRAM_Rd_Req and oSDRAM_Wr_Req are 0. Addresses and data hold their last driven values.
- Type mismatch: the granted client raises the glue request of the other type during GRANT. That request is ignored (not forwarded) and oErr[1] is set.
- Done pulses are ignored unless they come from the granted client with the matching type and arrive in GRANT. This includes Done during ACK and Done from a non-granted client.
- Watchdog: a 24-bit counter clears on entry to GRANT and increments each GRANT cycle.
  - When TIMEOUT≠0 and count reaches TIMEOUT: force release, set oErr[0], and drop oSDRAM_*_Req in the same cycle.
  - The client must re-request after a forced release.
- oC<k>_SDRAM_Data = iSDRAM_Data at all times for both clients.
- Reset values: all Acks 0, all done outputs 0, oSDRAM_Rd_Req=0, oSDRAM_Wr_Req=0, addresses 0, oSDRAM_Wr_Data 0, oGrant 0, oErr 0, state IDLE, watchdog counter 0.

## Timing
- Request seen high in IDLE at cycle n: ACK state at n+1, Ack high during n+1, GRANT from n+2.
- A client that drops Req on seeing Ack is never re-granted from the stale Req. Req is sampled only in IDLE.
- Glue and done routing through GRANT has zero added latency (combinational mux).
- Done at cycle m returns to IDLE at m+1. A pending request is acked at m+2. There is at least one idle cycle between grants.
- Simultaneous requests: only one Ack per ACK cycle. Losers keep Req high and are served in round-robin order.
- rst asserted mid-grant: next edge goes to IDLE with all outputs at reset values. The pointer returns to C0_WR.

## Test plan
- Single request: C0_WR Req at cycle 5 -> oC0_Wr_Ack high only in cycle 6. oGrant=3'b101 from cycle 7. The write glue passes through (addr 384000, data 0), iSDRAM_Wr_Done returns on oC0_SDRAM_Wr_Done, and oC1_SDRAM_Wr_Done stays 0.
- Round robin: all four Reqs held high, each source releasing after one transfer -> grant order C0_WR, C0_RD, C1_WR, C1_RD, C0_WR. There are exactly 2 cycles from each Done to the next Ack.
- Isolation: C1_RD granted while C0 drives SDRAM_Wr_Req=1 at addr 7215 -> oSDRAM_Wr_Req stays 0. C0_Wr_Done is ignored and the grant is held.
- Type mismatch: C0 granted for read asserts iC0_SDRAM_Wr_Req -> the request is not forwarded, oErr=2'b10, and the read continues normally.
- Watchdog: TIMEOUT=100 and C1_WR granted with no Done -> after 100 GRANT cycles the arbiter forces IDLE, sets oErr[0]=1, and drops oSDRAM_Wr_Req in the expiry cycle. A pending C0_RD is acked 2 cycles later.
- Reset mid-grant: rst pulse during a C0 write burst -> all outputs reach reset values after one edge. The first request after reset is arbitrated starting from C0_WR.
